// File: rtl/free_pointer_pool.sv
// Free-list manager: self-loads pointers 0..NUM_PTRS-1 after reset, hands them out and takes them back.
// Define FREE_POOL_DOUBLE_FREE_CHECK_EN to add the in-pool bitmap and double-free detection.
module free_pointer_pool #(
  parameter int unsigned NUM_PTRS = 1024,
  parameter int unsigned PTR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PTR_W-1:0] m_free_pointer,
  output logic             m_free_pointer_valid,
  input  logic             m_free_pointer_ready,
  input  logic [PTR_W-1:0] s_release_pointer,
  input  logic             s_release_valid,
  output logic             s_release_ready,
  output logic [PTR_W:0]   free_count,
  output logic             init_done,
  output logic             err_range,
  output logic             err_overflow,
  output logic             err_double_free
);

  localparam int unsigned   IDX_W    = (NUM_PTRS > 1) ? $clog2(NUM_PTRS) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(NUM_PTRS);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTRS - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             init_done_q, init_done_d;
  logic             err_range_q, err_range_d;
  logic             err_overflow_q, err_overflow_d;

  logic [IDX_W-1:0] mem_q [NUM_PTRS];
  logic             mem_we;
  logic [IDX_W-1:0] mem_wdata;

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] rel_idx;
  logic             alloc_fire;
  logic             rel_fire;
  logic             rel_range_bad;
  logic             rel_dup;
  logic             rel_full;
  logic             rel_accept;

  assign head    = mem_q[rd_ptr_q];
  assign rel_idx = s_release_pointer[IDX_W-1:0];

  assign m_free_pointer_valid = (state_q == ST_RUN) && (count_q != '0);
  assign m_free_pointer       = m_free_pointer_valid ? PTR_W'(head) : '0;
  assign s_release_ready      = (state_q == ST_RUN);

  assign alloc_fire    = m_free_pointer_valid && m_free_pointer_ready;
  assign rel_fire      = s_release_valid && s_release_ready;
  assign rel_range_bad = {1'b0, s_release_pointer} >= FULL_CNT;
  // A release into a full pool is legal when a pointer leaves in the same cycle.
  assign rel_full      = (count_q == FULL_CNT) && !alloc_fire;
  assign rel_accept    = rel_fire && !rel_range_bad && !rel_dup && !rel_full;

  assign free_count   = count_q;
  assign init_done    = init_done_q;
  assign err_range    = err_range_q;
  assign err_overflow = err_overflow_q;

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    err_range_d    = err_range_q;
    err_overflow_d = err_overflow_q;
    mem_we         = 1'b0;
    mem_wdata      = wr_ptr_q;
    unique case (state_q)
      ST_INIT: begin
        // wr_ptr doubles as the init counter and wraps back to 0 on exit.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE_IDX;
        count_d  = count_q + ONE_CNT;
        if (wr_ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (alloc_fire) begin
          rd_ptr_d = rd_ptr_q + ONE_IDX;
        end
        if (rel_accept) begin
          mem_we    = 1'b1;
          mem_wdata = rel_idx;
          wr_ptr_d  = wr_ptr_q + ONE_IDX;
        end
        if (alloc_fire && !rel_accept) begin
          count_d = count_q - ONE_CNT;
        end else if (!alloc_fire && rel_accept) begin
          count_d = count_q + ONE_CNT;
        end
        if (rel_fire && rel_range_bad) begin
          err_range_d = 1'b1;
        end
        if (rel_fire && !rel_range_bad && !rel_dup && rel_full) begin
          err_overflow_d = 1'b1;
        end
      end
    endcase
    init_done_d = init_done_q || (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      init_done_q    <= 1'b0;
      err_range_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      init_done_q    <= init_done_d;
      err_range_q    <= err_range_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

`ifdef FREE_POOL_DOUBLE_FREE_CHECK_EN
  logic [NUM_PTRS-1:0] in_pool_q, in_pool_d;
  logic                err_double_free_q, err_double_free_d;

  // Same pointer leaving and returning in one cycle is not a double free.
  assign rel_dup = in_pool_q[rel_idx] && !(alloc_fire && (head == rel_idx));
  assign err_double_free = err_double_free_q;

  always_comb begin
    in_pool_d         = in_pool_q;
    err_double_free_d = err_double_free_q;
    if (state_q == ST_INIT) begin
      in_pool_d[wr_ptr_q] = 1'b1;
    end else begin
      if (alloc_fire) begin
        in_pool_d[head] = 1'b0;
      end
      if (rel_accept) begin
        in_pool_d[rel_idx] = 1'b1;
      end
      if (rel_fire && !rel_range_bad && rel_dup) begin
        err_double_free_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_pool_q         <= '0;
      err_double_free_q <= 1'b0;
    end else begin
      in_pool_q         <= in_pool_d;
      err_double_free_q <= err_double_free_d;
    end
  end
`else
  assign rel_dup         = 1'b0;
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_free_pointer_pool.sv
// Scoreboard bench for free_pointer_pool with NUM_PTRS=16; expected pointers are queued by the
// stimulus and popped by a monitor on every allocation handshake.
module tb_free_pointer_pool;

  localparam int unsigned NP = 16;
  localparam int unsigned PW = 16;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] m_free_pointer;
  logic          m_free_pointer_valid;
  logic          m_free_pointer_ready;
  logic [PW-1:0] s_release_pointer;
  logic          s_release_valid;
  logic          s_release_ready;
  logic [PW:0]   free_count;
  logic          init_done;
  logic          err_range;
  logic          err_overflow;
  logic          err_double_free;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned exp_q[$];

  free_pointer_pool #(
    .NUM_PTRS(NP),
    .PTR_W   (PW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .m_free_pointer      (m_free_pointer),
    .m_free_pointer_valid(m_free_pointer_valid),
    .m_free_pointer_ready(m_free_pointer_ready),
    .s_release_pointer   (s_release_pointer),
    .s_release_valid     (s_release_valid),
    .s_release_ready     (s_release_ready),
    .free_count          (free_count),
    .init_done           (init_done),
    .err_range           (err_range),
    .err_overflow        (err_overflow),
    .err_double_free     (err_double_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: a handshake is seen at the negedge before the edge that completes it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_free_pointer_valid && m_free_pointer_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL alloc_unexpected: got pointer %0d, expected no allocation", m_free_pointer);
        end else begin
          check("alloc_ptr", m_free_pointer, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_one(input int unsigned p);
    s_release_pointer = PW'(p);
    s_release_valid   = 1'b1;
    step();
    s_release_valid   = 1'b0;
  endtask

  task automatic alloc_n(input int unsigned n);
    m_free_pointer_ready = 1'b1;
    for (int unsigned i = 0; i < n; i++) step();
    m_free_pointer_ready = 1'b0;
  endtask

  task automatic wait_init();
    int unsigned k;
    k = 0;
    while (!init_done && k < 40) begin
      step();
      k++;
    end
    check("init_done_wait", init_done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    check("rst_valid", m_free_pointer_valid, 0);
    check("rst_count", free_count, 0);
    check("rst_init_done", init_done, 0);
    check("rst_rel_ready", s_release_ready, 0);
    check("rst_errs", {err_range, err_overflow, err_double_free}, 0);
    rst_n = 1'b1;
    wait_init();
  endtask

  initial begin
    rst_n                = 1'b0;
    m_free_pointer_ready = 1'b0;
    s_release_pointer    = '0;
    s_release_valid      = 1'b0;
    repeat (3) step();

    // Reset state
    check("reset_valid", m_free_pointer_valid, 0);
    check("reset_pointer", m_free_pointer, 0);
    check("reset_count", free_count, 0);
    check("reset_init_done", init_done, 0);
    check("reset_rel_ready", s_release_ready, 0);
    check("reset_errs", {err_range, err_overflow, err_double_free}, 0);

    // Initialisation timing: init_done rises on the 17th edge after release of reset
    rst_n = 1'b1;
    for (int unsigned k = 1; k <= 17; k++) begin
      step();
      if (k == 5) begin
        check("init_count_5", free_count, 5);
        check("init_valid_low", m_free_pointer_valid, 0);
        check("init_rel_ready_low", s_release_ready, 0);
      end
      if (k == 16) begin
        check("init_done_edge16", init_done, 0);
        check("init_count_full", free_count, 16);
      end
    end
    check("init_done_edge17", init_done, 1);
    check("first_ptr", m_free_pointer, 0);
    check("first_valid", m_free_pointer_valid, 1);

    // Drain everything in order
    for (int unsigned i = 0; i < 16; i++) exp_q.push_back(i);
    alloc_n(16);
    check("drained_valid", m_free_pointer_valid, 0);
    check("drained_count", free_count, 0);

    // Release into empty pool: visible on the following cycle
    s_release_pointer = 7;
    s_release_valid   = 1'b1;
    check("empty_valid_before", m_free_pointer_valid, 0);
    step();
    s_release_valid = 1'b0;
    check("rel7_valid", m_free_pointer_valid, 1);
    check("rel7_ptr", m_free_pointer, 7);
    check("rel7_count", free_count, 1);
    exp_q.push_back(7);
    alloc_n(1);
    check("rel7_drained", free_count, 0);

    // No same-cycle bypass: ready held while releasing into empty pool
    exp_q.push_back(11);
    s_release_pointer    = 11;
    s_release_valid      = 1'b1;
    m_free_pointer_ready = 1'b1;
    step();
    s_release_valid = 1'b0;
    check("nobypass_count", free_count, 1);
    step();
    m_free_pointer_ready = 1'b0;
    check("nobypass_drained", free_count, 0);

    // Simultaneous allocate 3 / release 9
    release_one(3);
    release_one(5);
    check("two_in_pool", free_count, 2);
    exp_q.push_back(3);
    m_free_pointer_ready = 1'b1;
    s_release_pointer    = 9;
    s_release_valid      = 1'b1;
    step();
    m_free_pointer_ready = 1'b0;
    s_release_valid      = 1'b0;
    check("simul_count", free_count, 2);
    exp_q.push_back(5);
    exp_q.push_back(9);
    alloc_n(2);
    check("simul_drained", free_count, 0);

    // Refill to full with pointers 15..0
    for (int unsigned i = 0; i < 16; i++) release_one(15 - i);
    check("refill_count", free_count, 16);
    check("refill_head", m_free_pointer, 15);

    release_one(20);
    check("range_flag", err_range, 1);
    check("range_no_ovf", err_overflow, 0);
    check("range_no_dup", err_double_free, 0);
    check("range_count", free_count, 16);

    // Full pool, release legal because head leaves in the same cycle
    exp_q.push_back(15);
    m_free_pointer_ready = 1'b1;
    s_release_pointer    = 15;
    s_release_valid      = 1'b1;
    step();
    m_free_pointer_ready = 1'b0;
    s_release_valid      = 1'b0;
    check("full_swap_count", free_count, 16);
    check("full_swap_no_ovf", err_overflow, 0);
    check("full_swap_no_dup", err_double_free, 0);

    release_one(5);
    check("full_rel5_count", free_count, 16);
`ifdef FREE_POOL_DOUBLE_FREE_CHECK_EN
    check("full_rel5_dup", err_double_free, 1);
    check("full_rel5_ovf", err_overflow, 0);
`else
    check("full_rel5_ovf", err_overflow, 1);
    check("full_rel5_dup", err_double_free, 0);
`endif
    check("range_sticky", err_range, 1);

    // Double-release scenario from a fresh pool
    do_reset();
    exp_q.push_back(0);
    alloc_n(1);
    check("dbl_after_alloc", free_count, 15);
    release_one(0);
    check("dbl_first_count", free_count, 16);
    check("dbl_first_no_err", {err_overflow, err_double_free}, 0);
    release_one(0);
    check("dbl_second_count", free_count, 16);
`ifdef FREE_POOL_DOUBLE_FREE_CHECK_EN
    check("dbl_second_dup", err_double_free, 1);
    check("dbl_second_ovf", err_overflow, 0);
`else
    check("dbl_second_dup", err_double_free, 0);
    check("dbl_second_ovf", err_overflow, 1);
`endif

    // Reset mid-traffic with the pool half drained and valid/ready high
    do_reset();
    for (int unsigned i = 0; i < 8; i++) exp_q.push_back(i);
    m_free_pointer_ready = 1'b1;
    repeat (8) step();
    check("half_count", free_count, 8);
    check("half_valid", m_free_pointer_valid, 1);
    rst_n = 1'b0;
    step();
    check("midrst_valid", m_free_pointer_valid, 0);
    check("midrst_count", free_count, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_pointer", m_free_pointer, 0);
    rst_n                = 1'b1;
    m_free_pointer_ready = 1'b0;
    wait_init();
    check("reinit_count", free_count, 16);
    for (int unsigned i = 0; i < 16; i++) exp_q.push_back(i);
    alloc_n(16);
    check("reinit_drained", free_count, 0);
    check("reinit_valid", m_free_pointer_valid, 0);

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
